// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - request/result bundle between a binary source and the BCD converter
// Ports (master = requester, slave = converter):
//   bin_in  [IN_W-1:0]  master->slave  unsigned value to convert
//   start               master->slave  conversion request
//   busy                slave->master  conversion in progress
//   done                slave->master  one-cycle pulse, bcd_out/ovf just updated
//   ovf                 slave->master  last accepted value was clamped
//   bcd_out [15:0]      slave->master  packed BCD, thousands in [15:12]
interface bin2bcd_seq_if #(
    parameter int IN_W = 14
);
    logic [IN_W-1:0] bin_in;
    logic            start;
    logic            busy;
    logic            done;
    logic            ovf;
    logic [15:0]     bcd_out;

    modport master (
        output bin_in, start,
        input  busy, done, ovf, bcd_out
    );

    modport slave (
        input  bin_in, start,
        output busy, done, ovf, bcd_out
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter, one bit per clock
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  bin2bcd_seq_if.slave: bin_in/start in; busy/done/ovf/bcd_out out
module bin2bcd_seq #(
    parameter int IN_W    = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic         clk,
    input  logic         rst,
    bin2bcd_seq_if.slave bus
);
    localparam int                CNT_W    = $clog2(IN_W + 1);
    localparam logic [IN_W-1:0]   MAX_BIN  = IN_W'(MAX_VAL);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(IN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   bin_q, bin_d;
    logic [15:0]       scratch_q, scratch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_pend_q, ovf_pend_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       bcd_q, bcd_d;

    logic [15:0]       adj;
    logic [16+IN_W-1:0] shifted;

    // Add-3 correction per nibble; carries never cross nibbles because a
    // corrected digit (5..9 -> 8..12) still fits in 4 bits.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < 4; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj, bin_q} << 1;
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // Clamping keeps the result within four BCD digits.
                    if (bus.bin_in > MAX_BIN) begin
                        bin_d      = MAX_BIN;
                        ovf_pend_d = 1'b1;
                    end else begin
                        bin_d      = bus.bin_in;
                        ovf_pend_d = 1'b0;
                    end
                    scratch_d = 16'h0000;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                scratch_d = shifted[16+IN_W-1:IN_W];
                bin_d     = shifted[IN_W-1:0];
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bcd_d   = scratch_q;
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            scratch_q  <= 16'h0000;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            bcd_q      <= 16'h0000;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ovf     = ovf_q;
    assign bus.bcd_out = bcd_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;
    localparam int IN_W = 14;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bin2bcd_seq_if #(.IN_W(IN_W)) bus ();

    bin2bcd_seq #(.IN_W(IN_W), .MAX_VAL(9999)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [IN_W-1:0] bin;
        logic [15:0]     bcd;
        logic            ovf;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t popped;
    logic [15:0] held_bcd = 16'h0000;
    logic        held_ovf = 1'b0;
    logic        done_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [15:0] b, input logic o);
        exp_t e;
        e.bcd = b;
        e.ovf = o;
        sb.push_back(e);
    endtask

    // Scoreboard: each done pulse retires the oldest expectation; between
    // pulses bcd_out/ovf must hold the last expected result.
    always @(negedge clk) begin
        if (rst) begin
            held_bcd  = 16'h0000;
            held_ovf  = 1'b0;
            done_prev = 1'b0;
        end else begin
            if (bus.done) begin
                check("done_single_cycle", {31'd0, done_prev}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending conversion at %0t", $time);
                end else begin
                    popped   = sb.pop_front();
                    held_bcd = popped.bcd;
                    held_ovf = popped.ovf;
                end
            end
            done_prev = bus.done;
        end
        check("bcd_out", {16'd0, bus.bcd_out}, {16'd0, held_bcd});
        check("ovf", {31'd0, bus.ovf}, {31'd0, held_ovf});
    end

    task automatic run_one(input logic [IN_W-1:0] b, input logic [15:0] eb, input logic eo);
        int n;
        @(negedge clk);
        bus.bin_in = b;
        bus.start  = 1'b1;
        push_exp(eb, eo);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.bin_in = ~b;
        n = 0;
        while (n < 40) begin
            if (bus.done) break;
            check("busy_during_conv", {31'd0, bus.busy}, 32'd1);
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done at 15", n);
        end else begin
            check("done_latency", n, 32'd15);
            check("busy_after_done", {31'd0, bus.busy}, 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        int   n;
        vecs[0] = '{14'd1595,  16'h1595, 1'b0};
        vecs[1] = '{14'd0,     16'h0000, 1'b0};
        vecs[2] = '{14'd9999,  16'h9999, 1'b0};
        vecs[3] = '{14'd10000, 16'h9999, 1'b1};
        vecs[4] = '{14'd16383, 16'h9999, 1'b1};
        vecs[5] = '{14'd42,    16'h0042, 1'b0};
        vecs[6] = '{14'd5,     16'h0005, 1'b0};
        vecs[7] = '{14'd10,    16'h0010, 1'b0};
        vecs[8] = '{14'd1000,  16'h1000, 1'b0};
        vecs[9] = '{14'd8191,  16'h8191, 1'b0};

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_busy", {31'd0, bus.busy}, 32'd0);
            check("idle_done", {31'd0, bus.done}, 32'd0);
        end

        // Table of vectors
        for (int i = 0; i < 10; i++) begin
            run_one(vecs[i].bin, vecs[i].bcd, vecs[i].ovf);
        end

        // Start pulses while busy are ignored
        @(negedge clk);
        bus.bin_in = 14'd1595;
        bus.start  = 1'b1;
        push_exp(16'h1595, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k < 15) begin
                check("ign_busy", {31'd0, bus.busy}, 32'd1);
                check("ign_no_done", {31'd0, bus.done}, 32'd0);
            end else begin
                check("ign_done", {31'd0, bus.done}, 32'd1);
                check("ign_busy_low", {31'd0, bus.busy}, 32'd0);
            end
            if (k == 2 || k == 14) begin
                bus.bin_in = 14'd7;
                bus.start  = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("ign_stays_idle", {31'd0, bus.busy}, 32'd0);
        end

        // Continuous conversion with start held high
        @(negedge clk);
        bus.bin_in = 14'd1;
        bus.start  = 1'b1;
        push_exp(16'h0001, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.done && n < 40);
            if (!bus.done) begin
                checks++;
                errors++;
                $display("FAIL cont_timeout: got no done after %0d cycles expected 16", n);
            end else begin
                check("cont_spacing", n, 32'd16);
            end
            if (i < 3) begin
                bus.bin_in = IN_W'(i + 1);
                push_exp(16'(i + 1), 1'b0);
            end else begin
                bus.start = 1'b0;
            end
        end

        // Asynchronous reset in the middle of a conversion
        @(negedge clk);
        bus.bin_in = 14'd1595;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_bcd", {16'd0, bus.bcd_out}, 32'd0);
        check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            check("post_rst_idle", {31'd0, bus.busy}, 32'd0);
        end
        run_one(14'd8, 16'h0008, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
